// File: rtl/la_xtalmon_pkg.sv
// Shared types for the crystal-oscillator monitor.
package la_xtalmon_pkg;

    localparam int STATEW = 2;

    typedef enum logic [STATEW-1:0] {
        OFF    = 2'd0,
        WARMUP = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

endpackage

// File: rtl/la_dsync.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module la_dsync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/la_xtalmon.sv
// Crystal-oscillator startup/health monitor: counts synchronized xclk edges per
// window of the local clock and tracks lock / sticky fault.
module la_xtalmon
    import la_xtalmon_pkg::*;
#(
    parameter int WINDOW = 1024,
    parameter int CNTW   = 12,
    parameter int MINCNT = 200,
    parameter int MAXCNT = 300,
    parameter int GOODN  = 4,
    parameter int TMOUT  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clear,
    input  logic              xclk,
    output logic              ok,
    output logic              fail,
    output logic              done,
    output logic [CNTW-1:0]   count,
    output logic [STATEW-1:0] state
);

    localparam int WW = $clog2(WINDOW);
    localparam int GW = $clog2(GOODN + 1);
    localparam int TW = $clog2(TMOUT + 1);

    localparam logic [WW-1:0]   WLOAD = WW'(WINDOW - 1);
    localparam logic [GW-1:0]   GFULL = GW'(GOODN);
    localparam logic [TW-1:0]   TFULL = TW'(TMOUT);
    localparam logic [CNTW-1:0] CLO   = CNTW'(MINCNT);
    localparam logic [CNTW-1:0] CHI   = CNTW'(MAXCNT);

    state_t          st, st_n;
    logic            ok_n, fail_n;
    logic            xs, xprev, detect;
    logic            active, close, good, good_q;
    logic [WW-1:0]   wincnt;
    logic [CNTW-1:0] edgecnt, cnt_inc;
    logic [GW-1:0]   goodcnt;
    logic [TW-1:0]   winidx;

    la_dsync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (xclk),
        .q     (xs)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) xprev <= 1'b0;
        else       xprev <= xs;
    end

    assign state = st;

    always_comb begin
        detect  = xs & ~xprev;
        active  = en && (st != OFF);
        close   = active && (wincnt == '0);
        cnt_inc = (detect && (edgecnt != '1)) ? edgecnt + 1'b1 : edgecnt;
        good    = (cnt_inc >= CLO) && (cnt_inc <= CHI);
    end

    // FSM acts on the registered done pulse, so transitions land the cycle after done.
    always_comb begin
        st_n   = st;
        fail_n = fail;
        if (clear) fail_n = 1'b0;
        if (!en) begin
            st_n = OFF;
        end else begin
            case (st)
                OFF:     st_n = WARMUP;
                WARMUP:  if (done) begin
                             if (goodcnt == GFULL)     st_n = LOCKED;
                             else if (winidx == TFULL) st_n = FAULT;
                         end
                LOCKED:  if (done && !good_q) st_n = FAULT;
                FAULT:   if (clear) st_n = WARMUP;
                default: st_n = OFF;
            endcase
        end
        if ((st_n == FAULT) && (st != FAULT)) fail_n = 1'b1;
        ok_n = (st_n == LOCKED) && !fail_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st   <= OFF;
            ok   <= 1'b0;
            fail <= 1'b0;
        end else begin
            st   <= st_n;
            ok   <= ok_n;
            fail <= fail_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wincnt  <= '0;
            edgecnt <= '0;
            goodcnt <= '0;
            winidx  <= '0;
            good_q  <= 1'b0;
            count   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (st_n == OFF) begin
                wincnt  <= '0;
                edgecnt <= '0;
                goodcnt <= '0;
                winidx  <= '0;
                good_q  <= 1'b0;
            end else if ((st_n == WARMUP) && (st != WARMUP)) begin
                wincnt  <= WLOAD;
                edgecnt <= '0;
                goodcnt <= '0;
                winidx  <= '0;
                good_q  <= 1'b0;
            end else if (close) begin
                count   <= cnt_inc;
                edgecnt <= '0;
                wincnt  <= WLOAD;
                done    <= 1'b1;
                good_q  <= good;
                goodcnt <= !good ? '0 : ((goodcnt == GFULL) ? GFULL : goodcnt + 1'b1);
                winidx  <= (winidx == TFULL) ? TFULL : winidx + 1'b1;
            end else begin
                wincnt  <= wincnt - 1'b1;
                edgecnt <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_la_xtalmon.sv
// Directed bench for la_xtalmon with small windows and hand-computed counts.
`timescale 1ns/1ps
module tb_la_xtalmon;

    logic       clk = 1'b0;
    logic       reset, en, clear, xclk;
    logic       ok, fail, done;
    logic [5:0] count;
    logic [1:0] state;
    realtime    xhalf = 0.0;
    int         checks = 0;
    int         errors = 0;

    la_xtalmon #(
        .WINDOW (16),
        .CNTW   (6),
        .MINCNT (3),
        .MAXCNT (5),
        .GOODN  (2),
        .TMOUT  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clear (clear),
        .xclk  (xclk),
        .ok    (ok),
        .fail  (fail),
        .done  (done),
        .count (count),
        .state (state)
    );

    always #5 clk = ~clk;

    // Free-running oscillator model; xhalf == 0 holds xclk low.
    initial begin
        xclk = 1'b0;
        forever begin
            if (xhalf == 0.0) begin
                xclk = 1'b0;
                #1;
            end else begin
                #(xhalf) xclk = ~xclk;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 40);
        if (!done) check("done_wait", 0, 1);
    endtask

    task automatic set_xclk(input realtime h);
        xhalf = 0.0;
        repeat (2) tick();
        xhalf = h;
    endtask

    task automatic start_monitor();
        reset = 1'b0;
        repeat (4) tick();
        en = 1'b1;
    endtask

    initial begin
        int seen;
        int n;

        reset = 1'b1;
        en    = 1'b0;
        clear = 1'b0;
        xhalf = 20.0;
        repeat (3) tick();
        check("rst_state", state, 0);
        check("rst_ok", ok, 0);
        check("rst_fail", fail, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);

        // 1: clk/4 gives exactly 4 edges per 16-cycle window, lock after 2 windows
        start_monitor();
        tick();
        check("t1_warm", state, 1);
        wait_done();
        check("t1_cnt1", count, 4);
        check("t1_ok1", ok, 0);
        wait_done();
        check("t1_cnt2", count, 4);
        check("t1_st2", state, 1);
        tick();
        check("t1_ok", ok, 1);
        check("t1_lock", state, 2);

        // 2: oscillator stops while locked
        xhalf = 0.0;
        wait_done();
        check("t2_low", int'(count < 6'd3), 1);
        check("t2_okhold", ok, 1);
        tick();
        check("t2_fault", state, 3);
        check("t2_fail", fail, 1);
        check("t2_ok", ok, 0);
        wait_done();
        check("t2_zero", count, 0);
        set_xclk(20.0);
        wait_done();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t2_clr_st", state, 1);
        check("t2_clr_fail", fail, 0);
        wait_done();
        wait_done();
        tick();
        check("t2_relock", state, 2);
        check("t2_relock_ok", ok, 1);

        // 5: drop en mid-window while locked
        repeat (5) tick();
        en = 1'b0;
        tick();
        check("t5_off", state, 0);
        check("t5_ok", ok, 0);
        check("t5_done", done, 0);
        seen = 0;
        repeat (20) begin
            tick();
            if (done) seen = 1;
        end
        check("t5_nodone", seen, 0);
        en = 1'b1;
        tick();
        check("t5_warm", state, 1);
        wait_done();
        wait_done();
        tick();
        check("t5_relock", state, 2);
        check("t5_relock_ok", ok, 1);

        // 6: asynchronous reset mid-window while locked
        repeat (5) tick();
        check("t6_cnt_pre", count, 4);
        #2 reset = 1'b1;
        #1;
        check("t6_state", state, 0);
        check("t6_ok", ok, 0);
        check("t6_count", count, 0);
        check("t6_done", done, 0);
        check("t6_fail", fail, 0);
        en = 1'b0;

        // 3: xclk stuck low -> timeout after 8 windows
        xhalf = 0.0;
        repeat (3) tick();
        start_monitor();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            wait_done();
            check("t3_cnt", count, 0);
            if (ok) seen = 1;
        end
        check("t3_st8", state, 1);
        check("t3_fail8", fail, 0);
        tick();
        check("t3_fault", state, 3);
        check("t3_fail", fail, 1);
        if (ok) seen = 1;
        check("t3_never_ok", seen, 0);
        en = 1'b0;
        tick();
        check("t3_off", state, 0);
        check("t3_fail_kept", fail, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t3_off_clr", fail, 0);
        check("t3_off_stay", state, 0);

        // 4a: clk/2.5 -> 6..7 edges, out of range, timeout
        reset = 1'b1;
        set_xclk(12.5);
        start_monitor();
        for (int i = 0; i < 8; i++) begin
            wait_done();
            check("t4_hi", int'(count > 6'd5), 1);
        end
        tick();
        check("t4_fault", state, 3);
        check("t4_fail", fail, 1);

        // 4b: clk/3 -> mostly 5 edges, locks within the timeout
        reset = 1'b1;
        en    = 1'b0;
        set_xclk(15.0);
        start_monitor();
        n = 0;
        while (!ok && n < 10) begin
            wait_done();
            tick();
            n++;
        end
        check("t4_lock_ok", ok, 1);
        check("t4_lock_st", state, 2);
        check("t4_lock_fail", fail, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
